counter_share_arbiter: RTL and testbench
========================================

# counter_share_arbiter

Round-robin arbiter and sequencer that shares one auto-stopping up-counter between NUM_REQ requesters. Each requester supplies a start value. The block grants the counter to one requester, loads that start value, and counts up to all-ones. It then pulses `done` to the owner and releases the counter. It sits between client engines that need timed intervals and the single counter resource, and it contains that counter internally.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- WIDTH, 4, counter width in bits

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req  in  NUM_REQ  level request per client; held until that client's `done`
- start_val  in  NUM_REQ*WIDTH  per-client start value; slice i = bits [i*WIDTH +: WIDTH]; sampled only at grant
- gnt  out  NUM_REQ  one-hot owner, registered; all-zero when not running
- done  out  NUM_REQ  one-cycle pulse to the owner at end of run
- busy  out  1  high while in RUN
- owner  out  $clog2(NUM_REQ)  index of current or last owner
- count  out  WIDTH  shared counter value

## Operation
States: IDLE, RUN, DONE. All outputs are registered.

Reset:
- state=IDLE; gnt=0, done=0, busy=0, owner=0, count=0
- round-robin pointer ptr=0

IDLE:
- If req==0, stay in IDLE.
- Otherwise the winner w is the first set req bit searching from ptr upward, wrapping modulo NUM_REQ.
- Next cycle: state=RUN, gnt=1<<w, busy=1, owner=w, count=start_val[w], ptr=(w+1) mod NUM_REQ.

RUN:
- Each cycle, count<=count+1, computed in WIDTH+1 bits. The carry is the terminal flag.
- When count==all-ones, next cycle: state=DONE, count=0, gnt=0, busy=0, done[owner]=1.
- req changes during RUN, including deassertion by the owner, are ignored. A run always completes.
- start_val changes after grant have no effect.

DONE:
- done[owner]=1 for exactly this cycle. No arbitration takes place.
- Next cycle: state=IDLE, done=0.
- The owner must deassert req no later than the IDLE cycle after DONE, since its req is sampled at the end of that cycle. A still-asserted req is treated as a new request.

Arithmetic and invariants:
- Run length in RUN is 2^WIDTH − start_val cycles. start_val=all-ones gives 1 cycle; start_val=0 gives 2^WIDTH cycles.
- gnt and done are never both nonzero in the same cycle.
- gnt and done are each at most one-hot.
- busy == (gnt != 0).
- owner holds its value through DONE and IDLE.
- Reset asserted in any state, including mid-RUN, returns everything to reset values on the next edge. No done is issued for an aborted run.

## Timing
- Request-to-grant latency: 1 cycle. req is sampled high at the edge ending IDLE cycle T; gnt and the loaded count appear in T+1.
- Grant to done: 2^WIDTH − s cycles of RUN, then done in the following cycle.
- Minimum turnaround between runs: RUN → DONE → IDLE → RUN, i.e. 2 idle cycles between one run's last RUN cycle and the next grant's first RUN cycle.
- Fairness: with all requesters continuously requesting (re-asserting after IDLE), grants rotate 0,1,…,NUM_REQ−1,0… and no client waits more than NUM_REQ−1 runs.

## Test plan
- Reset then single request: req=4'b0100, start_val[2]=4'hC (WIDTH=4).
  - gnt=4'b0100 one cycle later; count 12,13,14,15.
  - DONE cycle has done=4'b0100, count=0, busy=0; then IDLE.
- Round-robin: req=4'b1111 reasserted after each done, all start_val=4'hF.
  - Grant order 0,1,2,3,0; each RUN lasts 1 cycle.
- Pointer wrap: after a grant to client 3, req=4'b1001.
  - Client 0 wins; next round client 3 wins.
- Boundary start values:
  - start_val=0 → RUN lasts 16 cycles, counting 0..15.
  - start_val=4'hF → RUN lasts 1 cycle.
- Owner drops req mid-RUN: run completes unchanged and done still pulses.
  - A late req from another client is granted only after IDLE.
- Reset mid-RUN at count=5: next cycle gnt=0, done=0, count=0, ptr=0.
  - Subsequent req=4'b0010 is granted to client 1.

Source files
------------

// File: rtl/counter_share_arbiter_if.sv
// Handshake bundle between client engines and the shared-counter arbiter.
// Latency: n/a (wiring only).
// Backpressure: none; clients hold req level until their done pulse.
interface counter_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4
);
    localparam int OW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] start_val;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic [OW-1:0]            owner;
    logic [WIDTH-1:0]         count;

    // Client side: raises requests and supplies start values.
    modport master (
        output req,
        output start_val,
        input  gnt,
        input  done,
        input  busy,
        input  owner,
        input  count
    );

    // Arbiter side: owns the counter and reports grant/done.
    modport slave (
        input  req,
        input  start_val,
        output gnt,
        output done,
        output busy,
        output owner,
        output count
    );
endinterface

// File: rtl/counter_share_arbiter.sv
// Round-robin arbiter sharing one auto-stopping up-counter between NUM_REQ clients.
// Latency: grant 1 cycle after req sampled in IDLE; done 1 cycle after count hits all-ones.
// Backpressure: none; a started run always completes, late requests wait for IDLE.
module counter_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    counter_share_arbiter_if.slave bus
);
    localparam int OW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] done_q;
    logic               busy_q;
    logic [OW-1:0]      owner_q;
    logic [WIDTH-1:0]   count_q;
    logic [OW-1:0]      ptr_q;

    logic               win_vld;
    logic [OW-1:0]      win;
    logic [WIDTH-1:0]   win_start;
    logic [OW-1:0]      ptr_next;
    logic [WIDTH:0]     count_inc;

    // Pick the first requester at or after the round-robin pointer, wrapping.
    always_comb begin
        win_vld   = 1'b0;
        win       = '0;
        win_start = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_vld && bus.req[(int'(ptr_q) + i) % NUM_REQ]) begin
                win_vld   = 1'b1;
                win       = OW'((int'(ptr_q) + i) % NUM_REQ);
                win_start = bus.start_val[((int'(ptr_q) + i) % NUM_REQ) * WIDTH +: WIDTH];
            end
        end
    end

    // Pointer moves just past the winner; explicit wrap keeps non-power-of-2 counts correct.
    assign ptr_next  = (win == OW'(NUM_REQ - 1)) ? '0 : win + OW'(1);

    // One extra bit so the carry out of all-ones marks the last RUN cycle.
    assign count_inc = {1'b0, count_q} + (WIDTH+1)'(1);

    // Sequencer: arbitrate in IDLE, count in RUN, pulse done for one cycle in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            count_q <= '0;
            ptr_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= '0;
                    if (win_vld) begin
                        state   <= RUN;
                        gnt_q   <= NUM_REQ'(1) << win;
                        busy_q  <= 1'b1;
                        owner_q <= win;
                        count_q <= win_start;
                        ptr_q   <= ptr_next;
                    end
                end
                RUN: begin
                    // Low bits of the increment are zero on carry, giving count=0 in DONE.
                    count_q <= count_inc[WIDTH-1:0];
                    if (count_inc[WIDTH]) begin
                        state  <= DONE;
                        gnt_q  <= '0;
                        busy_q <= 1'b0;
                        done_q <= NUM_REQ'(1) << owner_q;
                    end
                end
                DONE: begin
                    // No arbitration here: the owner gets this cycle to drop its req.
                    state  <= IDLE;
                    done_q <= '0;
                end
                default: begin
                    state  <= IDLE;
                    gnt_q  <= '0;
                    done_q <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.owner = owner_q;
    assign bus.count = count_q;
endmodule

// File: tb/tb_counter_share_arbiter.sv
// Bench for counter_share_arbiter: directed scenarios then random traffic vs a run-level model.
// Latency: model predicts outputs cycle by cycle from grant time, start value and run length.
// Backpressure: clients hold req until done, may drop early or re-request.
module tb_counter_share_arbiter;
    localparam int N = 4;
    localparam int W = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    counter_share_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    counter_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Run-level reference: remaining RUN cycles, elapsed cycles, pending done.
    int m_left    = 0;
    int m_elapsed = 0;
    int m_start   = 0;
    int m_owner   = 0;
    int m_ptr     = 0;
    bit m_done    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_step();
        bit found;
        if (reset) begin
            m_left = 0; m_elapsed = 0; m_start = 0;
            m_owner = 0; m_ptr = 0; m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            m_elapsed++;
            if (m_left == 0) m_done = 1'b1;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (bus.req != '0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && bus.req[(m_ptr + k) % N]) begin
                    found   = 1'b1;
                    m_owner = (m_ptr + k) % N;
                end
            end
            m_start   = int'(bus.start_val[m_owner*W +: W]);
            m_left    = (1 << W) - m_start;
            m_elapsed = 0;
            m_ptr     = (m_owner + 1) % N;
        end
    endtask

    task automatic compare();
        int exp_gnt, exp_done, exp_count;
        exp_gnt   = (m_left > 0) ? (1 << m_owner) : 0;
        exp_done  = m_done ? (1 << m_owner) : 0;
        exp_count = (m_left > 0) ? (m_start + m_elapsed) : 0;
        chk("gnt",   32'(bus.gnt),   32'(exp_gnt));
        chk("done",  32'(bus.done),  32'(exp_done));
        chk("busy",  32'(bus.busy),  32'(m_left > 0));
        chk("owner", 32'(bus.owner), 32'(m_owner));
        chk("count", 32'(bus.count), 32'(exp_count));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic set_sv(input int i, input int v);
        bus.start_val[i*W +: W] = W'(v);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    // Finish any run in progress, then leave one IDLE cycle with no requests.
    task automatic drain();
        int n;
        n = 0;
        while ((bus.busy || bus.done != '0) && n < 40) begin
            n++;
            if (bus.done != '0) bus.req = '0;
            cycle();
        end
        chk("drain_bound", 32'(n < 40), 32'd1);
        bus.req = '0;
        cycle();
    endtask

    // Measure RUN length for a lone client with a given start value.
    task automatic run_len(input int c, input int sv, input int exp_len);
        int n;
        set_sv(c, sv);
        bus.req = N'(1 << c);
        cycle();
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            cycle();
        end
        chk("run_len", 32'(n), 32'(exp_len));
        chk("run_done", 32'(bus.done), 32'(1 << c));
        bus.req = '0;
        cycle();
    endtask

    initial begin
        int n;
        reset         = 1'b1;
        bus.req       = '0;
        bus.start_val = '0;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();

        // Single request from client 2 starting at 12.
        set_sv(2, 4'hC);
        bus.req = 4'b0100;
        cycle();
        chk("t1_gnt", 32'(bus.gnt), 32'h4);
        chk("t1_cnt0", 32'(bus.count), 32'd12);
        cycle(); cycle(); cycle();
        chk("t1_cnt3", 32'(bus.count), 32'd15);
        cycle();
        chk("t1_done", 32'(bus.done), 32'h4);
        chk("t1_busy", 32'(bus.busy), 32'd0);
        bus.req = '0;
        cycle();

        // Round robin with everybody requesting and 1-cycle runs.
        do_reset();
        for (int i = 0; i < N; i++) set_sv(i, 4'hF);
        bus.req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            cycle();
            chk("rr_owner", 32'(bus.owner), 32'(r % N));
            cycle();
            cycle();
        end
        bus.req = '0;
        drain();

        // Pointer wrap after client 3 wins.
        do_reset();
        bus.req = 4'b1000;
        cycle();
        chk("wrap_first", 32'(bus.owner), 32'd3);
        cycle();
        bus.req = 4'b1001;
        cycle();
        cycle();
        chk("wrap_c0", 32'(bus.owner), 32'd0);
        cycle();
        cycle();
        cycle();
        chk("wrap_c3", 32'(bus.owner), 32'd3);
        bus.req = '0;
        drain();

        // Boundary start values.
        run_len(1, 0, 16);
        run_len(2, 15, 1);
        run_len(0, 9, 7);

        // Owner drops mid-run; late request waits for IDLE.
        set_sv(0, 8);
        set_sv(2, 14);
        bus.req = 4'b0001;
        cycle();
        cycle();
        bus.req = 4'b0100;
        n = 0;
        while (bus.done == '0 && n < 40) begin
            n++;
            cycle();
        end
        chk("drop_done", 32'(bus.done), 32'h1);
        cycle();
        chk("late_idle_gnt", 32'(bus.gnt), 32'd0);
        cycle();
        chk("late_gnt", 32'(bus.gnt), 32'h4);
        drain();

        // Reset in the middle of a run.
        set_sv(0, 0);
        bus.req = 4'b0001;
        cycle();
        for (int i = 0; i < 5; i++) cycle();
        chk("rst_mid_cnt", 32'(bus.count), 32'd5);
        bus.req = '0;
        reset   = 1'b1;
        cycle();
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        reset   = 1'b0;
        bus.req = 4'b0010;
        cycle();
        chk("rst_regrant", 32'(bus.gnt), 32'h2);
        drain();

        // Random traffic.
        for (int t = 0; t < 3000; t++) begin
            reset = ($urandom_range(0, 299) == 0);
            bus.start_val = N*W'($urandom);
            for (int i = 0; i < N; i++) begin
                if (m_done && m_owner == i) begin
                    if ($urandom_range(0, 3) != 0) bus.req[i] = 1'b0;
                end else if (m_left > 0 && m_owner == i) begin
                    if ($urandom_range(0, 39) == 0) bus.req[i] = 1'b0;
                end else if (!bus.req[i] && $urandom_range(0, 7) == 0) begin
                    bus.req[i] = 1'b1;
                end
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
